// File: rtl/prbs15_checker.sv
// prbs15_checker: self-synchronising PRBS15 (x^15+x^14+1) receiver with lock
// detection, windowed loss-of-lock and a saturating error counter.
module prbs15_checker #(
    parameter int LOCK_CNT = 32,
    parameter int WIN      = 64,
    parameter int LOSS_THR = 8,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             data_in,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             error_flag,
    output logic [ERR_W-1:0] error_count
);
    typedef enum logic {HUNT, LOCKED} state_e;

    state_e           state_q, state_d;
    logic [15:1]      s_q, s_d;
    logic [3:0]       fill_q, fill_d;
    logic [7:0]       match_q, match_d;
    logic [8:0]       win_cnt_q, win_cnt_d, win_err_q, win_err_d, win_err_nxt;
    logic             locked_q, locked_d, flag_q, flag_d;
    logic [ERR_W-1:0] cnt_q, cnt_d;
    logic             p, err;

    // s[1] is the newest bit; the prediction taps the two oldest
    assign p           = s_q[14] ^ s_q[15];
    assign err         = data_in != p;
    assign win_err_nxt = win_err_q + {8'd0, err};

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        fill_d    = fill_q;
        match_d   = match_q;
        win_cnt_d = win_cnt_q;
        win_err_d = win_err_q;
        locked_d  = locked_q;
        cnt_d     = cnt_q;
        flag_d    = 1'b0;
        if (en) begin
            if (state_q == HUNT) begin
                s_d    = {s_q[14:1], data_in};
                fill_d = (fill_q == 4'd15) ? fill_q : fill_q + 4'd1;
                // an all-zero register predicts zeros forever, so it never earns a match
                if (fill_q == 4'd15) begin
                    if (err) begin
                        match_d = '0;
                    end else if (s_q != '0) begin
                        match_d = match_q + 8'd1;
                        if (match_d == 8'(LOCK_CNT)) begin
                            state_d   = LOCKED;
                            locked_d  = 1'b1;
                            win_cnt_d = '0;
                            win_err_d = '0;
                        end
                    end
                end
            end else begin
                s_d = {s_q[14:1], p};
                if (err) begin
                    flag_d = 1'b1;
                    cnt_d  = (&cnt_q) ? cnt_q : cnt_q + ERR_W'(1);
                end
                if (win_err_nxt >= 9'(LOSS_THR)) begin
                    state_d  = HUNT;
                    locked_d = 1'b0;
                    fill_d   = '0;
                    match_d  = '0;
                end else if (win_cnt_q == 9'(WIN - 1)) begin
                    win_cnt_d = '0;
                    win_err_d = '0;
                end else begin
                    win_cnt_d = win_cnt_q + 9'd1;
                    win_err_d = win_err_nxt;
                end
            end
        end
        if (clear_cnt) cnt_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= HUNT;
            s_q       <= '0;
            fill_q    <= '0;
            match_q   <= '0;
            win_cnt_q <= '0;
            win_err_q <= '0;
            locked_q  <= 1'b0;
            flag_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            win_cnt_q <= win_cnt_d;
            win_err_q <= win_err_d;
            locked_q  <= locked_d;
            flag_q    <= flag_d;
            cnt_q     <= cnt_d;
        end
    end

    assign locked      = locked_q;
    assign error_flag  = flag_q;
    assign error_count = cnt_q;
endmodule

// File: tb/tb_prbs15_checker.sv
// tb_prbs15_checker: directed/randomised bench for prbs15_checker with a
// bit-history reference model; a second instance uses ERR_W=4, LOSS_THR=WIN.
module tb_prbs15_checker;
    logic        clk = 1'b0;
    logic        reset, en, data_in, clear_cnt;
    logic        lk0, fl0, lk1, fl1;
    logic [15:0] cnt0;
    logic [3:0]  cnt1;
    int          total = 0, bad = 0;
    int          m_fill[2], m_match[2], m_wc[2], m_we[2], m_cnt[2], m_h[2];
    bit          m_lk[2], m_fl[2];
    int          thr[2]  = '{8, 64};
    int          cmax[2] = '{65535, 15};
    logic [14:0] g;

    prbs15_checker dut0 (.clk(clk), .reset(reset), .en(en), .data_in(data_in), .clear_cnt(clear_cnt),
                         .locked(lk0), .error_flag(fl0), .error_count(cnt0));
    prbs15_checker #(.ERR_W(4), .LOSS_THR(64)) dut1 (.clk(clk), .reset(reset), .en(en), .data_in(data_in),
                         .clear_cnt(clear_cnt), .locked(lk1), .error_flag(fl1), .error_count(cnt1));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        for (int k = 0; k < 2; k++) begin
            m_fill[k] = 0; m_match[k] = 0; m_wc[k] = 0; m_we[k] = 0;
            m_cnt[k] = 0; m_h[k] = 0; m_lk[k] = 0; m_fl[k] = 0;
        end
    endfunction

    // history kept as an integer of the last 15 bits, newest in the units place
    function automatic void m_step(input int k, input bit e, input bit d, input bit c);
        int p, er;
        m_fl[k] = 0;
        if (e) begin
            p  = ((m_h[k] / 8192) ^ (m_h[k] / 16384)) % 2;
            er = (d != p) ? 1 : 0;
            if (!m_lk[k]) begin
                if (m_fill[k] == 15) begin
                    if (er == 1) m_match[k] = 0;
                    else if (m_h[k] != 0) begin
                        m_match[k] = m_match[k] + 1;
                        if (m_match[k] == 32) begin
                            m_lk[k] = 1; m_wc[k] = 0; m_we[k] = 0;
                        end
                    end
                end
                m_fill[k] = (m_fill[k] < 15) ? m_fill[k] + 1 : 15;
                m_h[k] = (m_h[k] * 2 + int'(d)) % 32768;
            end else begin
                m_h[k] = (m_h[k] * 2 + p) % 32768;
                if (er == 1) begin
                    m_fl[k] = 1;
                    if (m_cnt[k] < cmax[k]) m_cnt[k]++;
                end
                if (m_we[k] + er >= thr[k]) begin
                    m_lk[k] = 0; m_fill[k] = 0; m_match[k] = 0;
                end else if (m_wc[k] == 63) begin
                    m_wc[k] = 0; m_we[k] = 0;
                end else begin
                    m_wc[k]++; m_we[k] += er;
                end
            end
        end
        if (c) m_cnt[k] = 0;
    endfunction

    task automatic check_all();
        chk("locked0", lk0, m_lk[0]);
        chk("flag0", fl0, m_fl[0]);
        chk("count0", cnt0, m_cnt[0]);
        chk("locked1", lk1, m_lk[1]);
        chk("flag1", fl1, m_fl[1]);
        chk("count1", cnt1, m_cnt[1]);
    endtask

    task automatic tick(input bit e, input bit d, input bit c);
        en = e; data_in = d; clear_cnt = c;
        @(posedge clk);
        m_step(0, e, d, c);
        m_step(1, e, d, c);
        #1;
        check_all();
    endtask

    task automatic gen(output bit b);
        b = g[14] ^ g[13];
        g = {g[13:0], b};
    endtask

    task automatic do_reset();
        en = 1'b0; clear_cnt = 1'b0;
        reset = 1'b1;
        #2;
        m_reset();
        check_all();
        #4 reset = 1'b0;
        tick(0, 0, 0);
    endtask

    initial begin
        bit b;
        bit seen;
        int at;
        reset = 1'b1; en = 1'b0; data_in = 1'b0; clear_cnt = 1'b0; g = 15'h7FFF;
        m_reset();
        #3 check_all();
        #4 reset = 1'b0;
        tick(0, 0, 0);

        at = 0; seen = 0;
        for (int i = 1; i <= 500; i++) begin
            gen(b); tick(1, b, 0);
            if (at == 0 && lk0 === 1'b1) at = i;
            seen |= fl0;
        end
        chk("clean_lock_edge", at, 47);
        chk("clean_count", cnt0, 0);
        chk("clean_no_flag", seen, 0);

        gen(b); tick(1, ~b, 0);
        chk("single_flag", fl0, 1);
        gen(b); tick(1, b, 0);
        chk("single_flag_drop", fl0, 0);
        chk("single_count", cnt0, 1);
        chk("single_locked", lk0, 1);
        for (int j = 0; j < 7; j++) begin
            for (int i = $urandom_range(65, 90); i > 0; i--) begin gen(b); tick(1, b, 0); end
            gen(b); tick(1, ~b, 0);
        end
        chk("spread_count", cnt0, 8);
        chk("spread_locked", lk0, 1);

        for (int i = 0; i < 64 && m_wc[0] != 0; i++) begin gen(b); tick(1, b, 0); end
        for (int j = 1; j <= 8; j++) begin
            gen(b); tick(1, ~b, 0);
            if (j == 7) chk("burst_locked7", lk0, 1);
        end
        chk("burst_lost8", lk0, 0);
        chk("burst_count", cnt0, 16);
        at = 0;
        for (int i = 1; i <= 60; i++) begin
            gen(b); tick(1, b, 0);
            if (at == 0 && lk0 === 1'b1) at = i;
        end
        chk("relock_edge", at, 47);
        chk("count_frozen", cnt0, 16);

        do_reset();
        for (int i = 0; i < 200; i++) tick(1, 0, 0);
        chk("zero_line0", lk0, 0);
        chk("zero_line1", lk1, 0);

        do_reset();
        g = 15'h7FFF; at = 0;
        for (int c = 1; c <= 120; c++) begin
            if (c % 2 == 0) begin gen(b); tick(1, b, 0); end
            else tick(0, 1'($urandom_range(0, 1)), 0);
            if (at == 0 && lk0 === 1'b1) at = c;
        end
        chk("gapped_lock_clk", at, 94);

        do_reset();
        g = 15'h7FFF;
        for (int i = 0; i < 47; i++) begin gen(b); tick(1, b, 0); end
        chk("sat_lock0", lk0, 1);
        chk("sat_lock1", lk1, 1);
        for (int i = 0; i < 20; i++) begin gen(b); tick(1, ~b, 0); end
        chk("sat_count", cnt1, 15);
        chk("sat_locked", lk1, 1);
        gen(b); tick(1, ~b, 1);
        chk("clear_priority", cnt1, 0);
        gen(b); tick(1, ~b, 0);
        chk("after_clear", cnt1, 1);
        for (int i = 0; i < 60; i++) begin gen(b); tick(1, b, 0); end
        chk("pre_reset_lock0", lk0, 1);
        chk("pre_reset_lock1", lk1, 1);

        reset = 1'b1;
        #2;
        chk("async_lock0", lk0, 0);
        chk("async_count0", cnt0, 0);
        chk("async_lock1", lk1, 0);
        chk("async_count1", cnt1, 0);
        m_reset();
        #4 reset = 1'b0;
        tick(0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
